soc_interrupt_arbiter: RTL and testbench

Collects the SoC device interrupt lines (UART, timer, GPIO, SPI, Ethernet, PRNG, APU; INTERRUPT_SOURCES = 7) and presents one interrupt request plus a vector to the ApogeoRV core.
- Rising edges on the source lines are latched as pending.
- Pending sources are masked by a software enable register.
- The lowest-index enabled pending source is granted.
- Only one interrupt is in service at a time; an acknowledge / end-of-interrupt handshake sequences it.
- Configuration goes through a small register port driven by the MMIO bridge.

---
 rtl/soc_interrupt_arbiter.sv | 143 ++++++++++++++
 tb/tb_soc_interrupt_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_interrupt_arbiter.sv
// Interrupt arbiter for the SoC: latches rising edges, masks by enable, grants lowest
// index and sequences one interrupt at a time through request/ack/EOI.
module soc_interrupt_arbiter #(
  parameter int unsigned SOURCES      = 7,
  parameter int unsigned VECTOR_WIDTH = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [SOURCES-1:0]      interrupt_i,
  output logic                    interrupt_o,
  output logic [VECTOR_WIDTH-1:0] interrupt_vector_o,
  input  logic                    interrupt_ack_i,
  input  logic                    end_of_interrupt_i,
  input  logic                    write_i,
  input  logic                    read_i,
  input  logic [1:0]              address_i,
  input  logic [SOURCES-1:0]      write_data_i,
  output logic [SOURCES-1:0]      read_data_o
);

  localparam int unsigned STATUS_W     = VECTOR_WIDTH + 1;
  localparam int unsigned STATUS_WIDE  = SOURCES + STATUS_W;
  localparam logic [1:0]  ADDR_ENABLE  = 2'd0;
  localparam logic [1:0]  ADDR_PENDING = 2'd1;
  localparam logic [1:0]  ADDR_STATUS  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SOURCES-1:0]      prev_q;
  logic [SOURCES-1:0]      pending_q, pending_d;
  logic [SOURCES-1:0]      enable_q, enable_d;
  logic [SOURCES-1:0]      read_data_q, read_data_d;
  logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
  logic                    irq_q, irq_d;

  logic [SOURCES-1:0]      rise;
  logic [SOURCES-1:0]      eligible;
  logic [SOURCES-1:0]      vector_mask;
  logic [SOURCES-1:0]      ack_clear;
  logic [SOURCES-1:0]      w1c_clear;
  logic [VECTOR_WIDTH-1:0] winner;
  logic [STATUS_WIDE-1:0]  status_wide;
  logic                    ack_taken;
  logic                    vec_enabled;
  logic                    vec_pending;

  assign rise        = interrupt_i & ~prev_q;
  assign eligible    = pending_q & enable_q;
  assign vector_mask = SOURCES'(1) << vector_q;
  assign vec_enabled = |(enable_q & vector_mask);
  assign vec_pending = |(pending_q & vector_mask);
  assign ack_taken   = (state_q == REQUEST) && interrupt_ack_i;

  // Lowest-index eligible source wins.
  always_comb begin
    winner = '0;
    for (int i = int'(SOURCES) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = VECTOR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = REQUEST;
          vector_d = winner;
        end
      end
      REQUEST: begin
        // Ack beats withdraw; a masked or W1C'd source drops the request.
        if (interrupt_ack_i) begin
          state_d = SERVICE;
        end else if (!vec_enabled || !vec_pending) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (end_of_interrupt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQUEST);
  end

  // Pending/enable update and register read port; a new edge beats any clear.
  always_comb begin
    ack_clear   = ack_taken ? vector_mask : '0;
    w1c_clear   = (write_i && (address_i == ADDR_PENDING)) ? write_data_i : '0;
    pending_d   = (pending_q & ~(ack_clear | w1c_clear)) | rise;
    enable_d    = (write_i && (address_i == ADDR_ENABLE)) ? write_data_i : enable_q;

    status_wide                 = '0;
    status_wide[STATUS_W-1:1]   = vector_q;
    status_wide[0]              = (state_q == SERVICE);

    read_data_d = read_data_q;
    if (read_i) begin
      case (address_i)
        ADDR_ENABLE:  read_data_d = enable_q;
        ADDR_PENDING: read_data_d = pending_q;
        ADDR_STATUS:  read_data_d = SOURCES'(status_wide);
        default:      read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      read_data_q <= '0;
      vector_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= interrupt_i;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      read_data_q <= read_data_d;
      vector_q    <= vector_d;
      irq_q       <= irq_d;
    end
  end

  assign interrupt_o        = irq_q;
  assign interrupt_vector_o = vector_q;
  assign read_data_o        = read_data_q;

endmodule

// File: tb/tb_soc_interrupt_arbiter.sv
// Directed bench for soc_interrupt_arbiter: a vector table of single-shot requests
// followed by hand-written multi-cycle handshake and reset sequences.
module tb_soc_interrupt_arbiter;

  localparam int unsigned SOURCES = 7;
  localparam int unsigned VW      = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SOURCES-1:0] irq_in = '0;
  logic               irq_out;
  logic [VW-1:0]      vec_out;
  logic               ack = 1'b0;
  logic               eoi = 1'b0;
  logic               wr = 1'b0;
  logic               rd = 1'b0;
  logic [1:0]         addr = '0;
  logic [SOURCES-1:0] wdata = '0;
  logic [SOURCES-1:0] rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] en;
    logic [6:0] mask;
    logic [6:0] exp_pend;
    logic       exp_irq;
    logic [2:0] exp_vec;
  } vec_t;

  vec_t tbl[7];

  soc_interrupt_arbiter #(.SOURCES(SOURCES)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .interrupt_i        (irq_in),
    .interrupt_o        (irq_out),
    .interrupt_vector_o (vec_out),
    .interrupt_ack_i    (ack),
    .end_of_interrupt_i (eoi),
    .write_i            (wr),
    .read_i             (rd),
    .address_i          (addr),
    .write_data_i       (wdata),
    .read_data_o        (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    irq_in = '0;
    ack    = 1'b0;
    eoi    = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    addr   = '0;
    wdata  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [6:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [6:0] d);
    addr = a;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d  = rdata;
  endtask

  task automatic pulse_src(input logic [6:0] m);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  logic [6:0] d;

  initial begin
    tbl[0] = '{en: 7'h7F, mask: 7'h08, exp_pend: 7'h08, exp_irq: 1'b1, exp_vec: 3'd3};
    tbl[1] = '{en: 7'h7F, mask: 7'h24, exp_pend: 7'h24, exp_irq: 1'b1, exp_vec: 3'd2};
    tbl[2] = '{en: 7'h00, mask: 7'h40, exp_pend: 7'h40, exp_irq: 1'b0, exp_vec: 3'd0};
    tbl[3] = '{en: 7'h7F, mask: 7'h7F, exp_pend: 7'h7F, exp_irq: 1'b1, exp_vec: 3'd0};
    tbl[4] = '{en: 7'h70, mask: 7'h3C, exp_pend: 7'h3C, exp_irq: 1'b1, exp_vec: 3'd4};
    tbl[5] = '{en: 7'h01, mask: 7'h7E, exp_pend: 7'h7E, exp_irq: 1'b0, exp_vec: 3'd0};
    tbl[6] = '{en: 7'h40, mask: 7'h40, exp_pend: 7'h40, exp_irq: 1'b1, exp_vec: 3'd6};

    // Reset values while held in reset
    @(negedge clk);
    check("rst_irq", 32'(irq_out), 32'h0);
    check("rst_vec", 32'(vec_out), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);

    // Table: single pulse, request appears two cycles after the edge
    for (int r = 0; r < 7; r++) begin
      do_reset();
      reg_write(2'd0, tbl[r].en);
      pulse_src(tbl[r].mask);
      check($sformatf("row%0d_irq_early", r), 32'(irq_out), 32'h0);
      @(negedge clk);
      check($sformatf("row%0d_irq", r), 32'(irq_out), 32'(tbl[r].exp_irq));
      check($sformatf("row%0d_vec", r), 32'(vec_out), 32'(tbl[r].exp_vec));
      reg_read(2'd1, d);
      check($sformatf("row%0d_pend", r), 32'(d), 32'(tbl[r].exp_pend));
    end

    // A: full ack / EOI handshake on source 3
    do_reset();
    reg_write(2'd0, 7'h7F);
    pulse_src(7'h08);
    @(negedge clk);
    check("a_irq", 32'(irq_out), 32'h1);
    check("a_vec", 32'(vec_out), 32'h3);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("a_irq_after_ack", 32'(irq_out), 32'h0);
    reg_read(2'd1, d);
    check("a_pend_after_ack", 32'(d), 32'h00);
    reg_read(2'd2, d);
    check("a_status_service", 32'(d), 32'h07);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    repeat (2) @(negedge clk);
    check("a_irq_after_eoi", 32'(irq_out), 32'h0);
    reg_read(2'd2, d);
    check("a_status_idle", 32'(d), 32'h06);

    // B: simultaneous edges on 5 and 2, then re-arbitration after EOI
    do_reset();
    reg_write(2'd0, 7'h7F);
    pulse_src(7'h24);
    @(negedge clk);
    check("b_vec_first", 32'(vec_out), 32'h2);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    check("b_irq_gap", 32'(irq_out), 32'h0);
    @(negedge clk);
    check("b_irq_second", 32'(irq_out), 32'h1);
    check("b_vec_second", 32'(vec_out), 32'h5);
    ack = 1'b1;
    eoi = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    eoi = 1'b0;
    reg_read(2'd2, d);
    check("b_ack_eoi_same", 32'(d), 32'h0B);

    // C: masked pending, stray ack/EOI ignored, enable raises request
    do_reset();
    pulse_src(7'h41);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    reg_read(2'd1, d);
    check("c_pend_ack_idle", 32'(d), 32'h41);
    check("c_irq_masked", 32'(irq_out), 32'h0);
    reg_write(2'd0, 7'h40);
    check("c_irq_early", 32'(irq_out), 32'h0);
    @(negedge clk);
    check("c_irq", 32'(irq_out), 32'h1);
    check("c_vec", 32'(vec_out), 32'h6);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    @(negedge clk);
    check("c_eoi_in_request", 32'(irq_out), 32'h1);

    // D: withdraw by masking, then re-enable
    do_reset();
    reg_write(2'd0, 7'h7F);
    pulse_src(7'h10);
    @(negedge clk);
    check("d_vec", 32'(vec_out), 32'h4);
    reg_write(2'd0, 7'h00);
    check("d_irq_hold", 32'(irq_out), 32'h1);
    @(negedge clk);
    check("d_irq_withdrawn", 32'(irq_out), 32'h0);
    reg_read(2'd1, d);
    check("d_pend_kept", 32'(d), 32'h10);
    reg_write(2'd0, 7'h7F);
    check("d_irq_reenable_early", 32'(irq_out), 32'h0);
    @(negedge clk);
    check("d_irq_reenable", 32'(irq_out), 32'h1);
    check("d_vec_reenable", 32'(vec_out), 32'h4);

    // E: held level gives one edge; rise beats ack clear
    do_reset();
    irq_in = 7'h02;
    repeat (3) @(negedge clk);
    reg_read(2'd1, d);
    check("e_held_pend", 32'(d), 32'h02);
    reg_write(2'd1, 7'h02);
    repeat (2) @(negedge clk);
    reg_read(2'd1, d);
    check("e_held_no_reedge", 32'(d), 32'h00);
    irq_in = '0;
    reg_write(2'd0, 7'h7F);
    pulse_src(7'h02);
    @(negedge clk);
    check("e_vec", 32'(vec_out), 32'h1);
    irq_in = 7'h02;
    ack    = 1'b1;
    @(negedge clk);
    ack    = 1'b0;
    irq_in = '0;
    check("e_irq_after_ack", 32'(irq_out), 32'h0);
    reg_read(2'd1, d);
    check("e_set_wins", 32'(d), 32'h02);
    reg_read(2'd2, d);
    check("e_status", 32'(d), 32'h03);

    // F: reset during service, then register port corners
    do_reset();
    reg_write(2'd0, 7'h7F);
    pulse_src(7'h04);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    pulse_src(7'h20);
    reg_read(2'd2, d);
    check("f_status_service", 32'(d), 32'h05);
    check("f_irq_service", 32'(irq_out), 32'h0);
    rst_n = 1'b0;
    #1;
    check("f_rst_irq", 32'(irq_out), 32'h0);
    check("f_rst_vec", 32'(vec_out), 32'h0);
    check("f_rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reg_read(2'd0, d);
    check("f_enable_cleared", 32'(d), 32'h00);
    reg_read(2'd1, d);
    check("f_pending_cleared", 32'(d), 32'h00);
    reg_read(2'd2, d);
    check("f_status_cleared", 32'(d), 32'h00);
    reg_write(2'd0, 7'h55);
    reg_read(2'd0, d);
    check("f_enable_rw", 32'(d), 32'h55);
    @(negedge clk);
    check("f_rdata_hold", 32'(rdata), 32'h55);
    reg_write(2'd3, 7'h7F);
    reg_read(2'd3, d);
    check("f_addr3", 32'(d), 32'h00);
    reg_read(2'd0, d);
    check("f_addr3_no_effect", 32'(d), 32'h55);
    addr  = 2'd0;
    wdata = 7'h2A;
    wr    = 1'b1;
    rd    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check("f_read_prewrite", 32'(rdata), 32'h55);
    reg_read(2'd0, d);
    check("f_read_postwrite", 32'(d), 32'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
